// File: rtl/sram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port lane-masked SRAM among NREQ requesters, with zero-fill after reset.
// One access per cycle, read data one cycle after accept; losers see READY=0 and must hold, responses have no backpressure.
module sram_sp_arbiter #(
  parameter int SIZE    = 4,
  parameter int WLEN    = 32,
  parameter int STEP    = 2,
  parameter int NREQ    = 2,
  parameter int INIT_EN = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           REQ_VALID,
  output logic [NREQ-1:0]           REQ_READY,
  input  logic [NREQ*SIZE-1:0]      REQ_A,
  input  logic [NREQ*(2**STEP)-1:0] REQ_WEN,
  input  logic [NREQ*WLEN-1:0]      REQ_D,
  output logic [NREQ-1:0]           RSP_VALID,
  output logic [WLEN-1:0]           RSP_Q,
  output logic                      INIT_DONE,
  output logic                      CEN,
  output logic [(2**STEP)-1:0]      WEN,
  output logic [SIZE-1:0]           A,
  output logic [WLEN-1:0]           D,
  input  logic [WLEN-1:0]           Q
);

  localparam int NL = 2**STEP;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [WLEN-1:0] rsp_hold_q, rsp_hold_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [WLEN-1:0] d_q, d_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_ok;
  logic [NL-1:0]   gnt_wen;
  logic [SIZE-1:0] gnt_a;
  logic [WLEN-1:0] gnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_hold_q <= '0;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_hold_q <= rsp_hold_d;
      a_q        <= a_d;
      d_q        <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  // First valid requester at or after the round-robin pointer, wrapping mod NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && REQ_VALID[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  assign gnt_ok  = gnt_vld && (state_q == ST_RUN) && !RST;
  assign gnt_wen = REQ_WEN[gnt_idx*NL +: NL];
  assign gnt_a   = REQ_A[gnt_idx*SIZE +: SIZE];
  assign gnt_d   = REQ_D[gnt_idx*WLEN +: WLEN];

  always_comb begin
    REQ_READY = '0;
    CEN       = 1'b1;
    WEN       = '1;
    a_d       = a_q;
    d_d       = d_q;
    ptr_d     = ptr_q;
    rsp_vld_d = '0;
    if (!RST && state_q == ST_INIT) begin
      CEN = 1'b0;
      WEN = '0;
      a_d = cnt_q;
      d_d = '0;
    end else if (gnt_ok) begin
      REQ_READY[gnt_idx] = 1'b1;
      CEN   = 1'b0;
      WEN   = gnt_wen;
      a_d   = gnt_a;
      d_d   = gnt_d;
      ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (&gnt_wen) rsp_vld_d[gnt_idx] = 1'b1;
    end
  end

  // Q is only meaningful in the cycle after a read; otherwise replay the last response.
  assign RSP_Q      = (|rsp_vld_q) ? Q : rsp_hold_q;
  assign rsp_hold_d = RSP_Q;
  assign RSP_VALID  = rsp_vld_q;
  assign INIT_DONE  = (state_q == ST_RUN);
  assign A          = a_d;
  assign D          = d_d;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
module tb_sram_sp_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_READY;
  logic [7:0]  REQ_A;
  logic [7:0]  REQ_WEN;
  logic [63:0] REQ_D;
  logic [1:0]  RSP_VALID;
  logic [31:0] RSP_Q;
  logic        INIT_DONE;
  logic        CEN;
  logic [3:0]  WEN;
  logic [3:0]  A;
  logic [31:0] D;
  logic [31:0] Q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sram_sp_arbiter #(.SIZE(4), .WLEN(32), .STEP(2), .NREQ(2), .INIT_EN(1)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_WEN(REQ_WEN), .REQ_D(REQ_D), .RSP_VALID(RSP_VALID),
    .RSP_Q(RSP_Q), .INIT_DONE(INIT_DONE), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  // Behavioural lane-masked single-port SRAM; pre-filled with junk so the zero-fill is visible.
  logic [31:0] mem [16];
  int fill_cnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++) if (!wen[j]) r[j*8 +: 8] = nd[j*8 +: 8];
    return r;
  endfunction

  always @(posedge CLK) begin
    if (fill_cnt < 16) begin
      mem[fill_cnt] <= 32'hDEADBEEF;
      fill_cnt      <= fill_cnt + 1;
    end else if (!CEN) begin
      mem[A] <= merge(mem[A], D, WEN);
      Q      <= merge(mem[A], D, WEN);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] a, input logic [3:0] wen, input logic [31:0] d);
    REQ_VALID[r]       = 1'b1;
    REQ_A[r*4 +: 4]    = a;
    REQ_WEN[r*4 +: 4]  = wen;
    REQ_D[r*32 +: 32]  = d;
  endtask

  task automatic clr_req(input int r);
    REQ_VALID[r] = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_req(0, 4'd0, 4'hF, 32'h0);
    set_req(1, 4'd0, 4'hF, 32'h0);
    repeat (20) tick();
    #1;
    n_cmp++; if (REQ_READY !== 2'b00) begin n_bad++; $display("FAIL rst_ready got %b want 00", REQ_READY); end
    n_cmp++; if (CEN !== 1'b1 || WEN !== 4'hF) begin n_bad++; $display("FAIL rst_sram got CEN=%b WEN=%b want 1 1111", CEN, WEN); end
    n_cmp++; if (RSP_VALID !== 2'b00 || RSP_Q !== 32'h0) begin n_bad++; $display("FAIL rst_rsp got %b %h want 00 0", RSP_VALID, RSP_Q); end
    n_cmp++; if (INIT_DONE !== 1'b0) begin n_bad++; $display("FAIL rst_init_done got %b want 0", INIT_DONE); end
  endtask

  task automatic test_init();
    RST = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++;
      if (CEN !== 1'b0 || WEN !== 4'h0 || A !== 4'(i) || REQ_READY !== 2'b00 || INIT_DONE !== 1'b0) begin
        n_bad++;
        $display("FAIL init_cycle%0d got CEN=%b WEN=%b A=%0d RDY=%b DONE=%b want 0 0000 %0d 00 0", i, CEN, WEN, A, REQ_READY, INIT_DONE, i);
      end
      tick();
    end
    clr_req(0);
    clr_req(1);
    #1;
    n_cmp++; if (INIT_DONE !== 1'b1) begin n_bad++; $display("FAIL init_done got %b want 1", INIT_DONE); end
    for (int i = 0; i < 16; i++) begin
      set_req(0, 4'(i), 4'hF, 32'h0);
      #1;
      n_cmp++; if (REQ_READY !== 2'b01) begin n_bad++; $display("FAIL init_rd_ready%0d got %b want 01", i, REQ_READY); end
      tick();
      n_cmp++;
      if (RSP_VALID !== 2'b01 || RSP_Q !== 32'h0) begin
        n_bad++; $display("FAIL init_rd%0d got %b %h want 01 00000000", i, RSP_VALID, RSP_Q);
      end
    end
    clr_req(0);
    tick();
  endtask

  task automatic test_masked_write();
    set_req(0, 4'd3, 4'b0000, 32'hAABBCCDD);
    #1;
    n_cmp++; if (REQ_READY !== 2'b01) begin n_bad++; $display("FAIL mw_ready got %b want 01", REQ_READY); end
    tick();
    set_req(0, 4'd3, 4'b1010, 32'h11223344);
    n_cmp++; if (RSP_VALID !== 2'b00) begin n_bad++; $display("FAIL mw_no_rsp got %b want 00", RSP_VALID); end
    tick();
    set_req(0, 4'd3, 4'hF, 32'h0);
    tick();
    clr_req(0);
    n_cmp++;
    if (RSP_VALID !== 2'b01 || RSP_Q !== 32'hAA22CC44) begin
      n_bad++; $display("FAIL mw_read got %b %h want 01 aa22cc44", RSP_VALID, RSP_Q);
    end
    tick();
    n_cmp++;
    if (RSP_VALID !== 2'b00 || RSP_Q !== 32'hAA22CC44) begin
      n_bad++; $display("FAIL mw_hold got %b %h want 00 aa22cc44", RSP_VALID, RSP_Q);
    end
    // r1 write leaves the pointer on r0 for the contention test.
    set_req(1, 4'd5, 4'b0000, 32'h55555555);
    #1;
    n_cmp++; if (REQ_READY !== 2'b10) begin n_bad++; $display("FAIL mw_r1_ready got %b want 10", REQ_READY); end
    tick();
    clr_req(1);
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 4'd3, 4'hF, 32'h0);
    set_req(1, 4'd5, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (REQ_READY !== exp_rdy[k]) begin n_bad++; $display("FAIL cont_ready%0d got %b want %b", k, REQ_READY, exp_rdy[k]); end
      tick();
      n_cmp++;
      if (RSP_VALID !== exp_rdy[k] || RSP_Q !== (exp_rdy[k][0] ? 32'hAA22CC44 : 32'h55555555)) begin
        n_bad++; $display("FAIL cont_rsp%0d got %b %h want %b", k, RSP_VALID, RSP_Q, exp_rdy[k]);
      end
    end
    clr_req(0);
    clr_req(1);
    tick();
  endtask

  task automatic test_back_to_back();
    set_req(1, 4'd7, 4'b0000, 32'h5);
    #1;
    n_cmp++; if (REQ_READY !== 2'b10 || CEN !== 1'b0) begin n_bad++; $display("FAIL b2b_wr got RDY=%b CEN=%b want 10 0", REQ_READY, CEN); end
    tick();
    set_req(1, 4'd7, 4'hF, 32'h0);
    #1;
    n_cmp++; if (REQ_READY !== 2'b10 || CEN !== 1'b0) begin n_bad++; $display("FAIL b2b_rd got RDY=%b CEN=%b want 10 0", REQ_READY, CEN); end
    tick();
    clr_req(1);
    n_cmp++;
    if (RSP_VALID !== 2'b10 || RSP_Q !== 32'h5) begin
      n_bad++; $display("FAIL b2b_data got %b %h want 10 00000005", RSP_VALID, RSP_Q);
    end
    tick();
  endtask

  task automatic test_starvation();
    int got;
    got = -1;
    set_req(0, 4'd3, 4'hF, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (REQ_READY !== 2'b01) begin n_bad++; $display("FAIL starve_r0_%0d got %b want 01", c, REQ_READY); end
      tick();
    end
    set_req(1, 4'd7, 4'hF, 32'h0);
    for (int w = 0; w < 2 && got < 0; w++) begin
      #1;
      if (REQ_READY == 2'b10) got = w;
      tick();
    end
    clr_req(1);
    n_cmp++; if (got !== 0) begin n_bad++; $display("FAIL starve_r1_grant got cycle %0d want 0", got); end
    #1;
    n_cmp++; if (REQ_READY !== 2'b01) begin n_bad++; $display("FAIL starve_r0_back got %b want 01", REQ_READY); end
    tick();
    clr_req(0);
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    set_req(0, 4'd9, 4'b0000, 32'h12345678);
    tick();
    set_req(0, 4'd9, 4'hF, 32'h0);
    #1;
    n_cmp++; if (REQ_READY !== 2'b01) begin n_bad++; $display("FAIL rm_rd_ready got %b want 01", REQ_READY); end
    tick();
    RST = 1'b1;
    set_req(1, 4'd9, 4'hF, 32'h0);
    #1;
    n_cmp++; if (REQ_READY !== 2'b00 || CEN !== 1'b1 || WEN !== 4'hF) begin n_bad++; $display("FAIL rm_rst_comb got RDY=%b CEN=%b WEN=%b want 00 1 1111", REQ_READY, CEN, WEN); end
    tick();
    clr_req(0);
    clr_req(1);
    n_cmp++; if (RSP_VALID !== 2'b00 || RSP_Q !== 32'h0 || INIT_DONE !== 1'b0) begin n_bad++; $display("FAIL rm_dropped got %b %h %b want 00 0 0", RSP_VALID, RSP_Q, INIT_DONE); end
    RST = 1'b0;
    n = 0;
    while (!INIT_DONE && n < 40) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL rm_init_len got %0d want 16", n); end
    set_req(1, 4'd9, 4'hF, 32'h0);
    tick();
    set_req(1, 4'd3, 4'hF, 32'h0);
    n_cmp++; if (RSP_VALID !== 2'b10 || RSP_Q !== 32'h0) begin n_bad++; $display("FAIL rm_a9 got %b %h want 10 00000000", RSP_VALID, RSP_Q); end
    tick();
    clr_req(1);
    n_cmp++; if (RSP_VALID !== 2'b10 || RSP_Q !== 32'h0) begin n_bad++; $display("FAIL rm_a3 got %b %h want 10 00000000", RSP_VALID, RSP_Q); end
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_A     = '0;
    REQ_WEN   = '1;
    REQ_D     = '0;
    test_reset();
    test_init();
    test_masked_write();
    test_contention();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
